// File: rtl/jtiming_pkg.sv
// Shared timing definitions for the clock-phase generator and its step ring.
package jtiming_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_0 = 2'd0;
  localparam phase_t PH_1 = 2'd1;
  localparam phase_t PH_2 = 2'd2;
  localparam phase_t PH_3 = 2'd3;

  localparam int NSTEPS = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TICK   = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

  // Phase to {clk, clkd}: clkd is clk delayed by one phase.
  function automatic logic [1:0] phase_clocks(input phase_t ph);
    logic [1:0] pair;
    case (ph)
      PH_0:    pair = 2'b10;
      PH_1:    pair = 2'b11;
      PH_2:    pair = 2'b01;
      PH_3:    pair = 2'b00;
      default: pair = 2'b00;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/jstepper.sv
// One-hot step ring; resets to the last step so the first advance lands on step 0.
module jstepper
  import jtiming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [0:NSTEPS-1] stp_bus
);

  // Rotate toward higher indices; the last step wraps to step 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stp_bus <= 6'b000001;
    end else if (advance) begin
      stp_bus <= {stp_bus[NSTEPS-1], stp_bus[0:NSTEPS-2]};
    end else begin
      stp_bus <= stp_bus;
    end
  end

endmodule

// File: rtl/jclock_stepper.sv
// Four-phase CPU clock generator with run / single-step / halt control and a
// six-step one-hot stepper; every output is a register.
module jclock_stepper
  import jtiming_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       halt,
  output logic       CLK_clk,
  output logic       CLK_clkd,
  output logic       CLK_clke,
  output logic       CLK_clks,
  output logic [0:5] STP_bus,
  output logic       halted,
  output logic       cycle_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  ctrl_state_t   state_r, state_s;
  phase_t        ph_r, ph_s;
  logic [PW-1:0] pre_r, pre_s;
  logic          halted_s;
  logic          advance_s;
  logic          cycle_done_s;
  logic [1:0]    pair_s;
  logic          last_clk_s;

  assign last_clk_s = (pre_r == PRE_LAST);
  assign pair_s     = phase_clocks(ph_s);

  // Next-state logic for the control FSM, prescaler and phase counter.
  always_comb begin
    state_s   = state_r;
    ph_s      = ph_r;
    pre_s     = pre_r;
    halted_s  = halted;
    advance_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run || step) begin
          state_s   = ST_TICK;
          ph_s      = PH_0;
          pre_s     = {PW{1'b0}};
          advance_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TICK: begin
        if (!last_clk_s) begin
          pre_s = pre_r + PW'(1);
        end else if (ph_r == PH_3) begin
          pre_s = {PW{1'b0}};
          if (halted) begin
            state_s = ST_HALTED;
          end else if (run) begin
            ph_s      = PH_0;
            advance_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          pre_s = {PW{1'b0}};
          ph_s  = ph_r + 2'd1;
          // Halt is only honoured at the close of phase 1 of the final step.
          if ((ph_r == PH_1) && STP_bus[NSTEPS-1] && halt) begin
            halted_s = 1'b1;
          end else begin
            halted_s = halted;
          end
        end
      end
      ST_HALTED: begin
        state_s = ST_HALTED;
      end
      default: begin
        state_s = ST_IDLE;
        ph_s    = PH_3;
        pre_s   = {PW{1'b0}};
      end
    endcase
    // STP_bus only moves on entry to phase 0, so its current value is valid here.
    cycle_done_s = (state_s == ST_TICK) && (ph_s == PH_3) && (pre_s == PRE_LAST)
                   && STP_bus[NSTEPS-1];
  end

  // State and output registers, loaded from next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ph_r       <= PH_3;
      pre_r      <= {PW{1'b0}};
      halted     <= 1'b0;
      cycle_done <= 1'b0;
      CLK_clk    <= 1'b0;
      CLK_clkd   <= 1'b0;
      CLK_clke   <= 1'b0;
      CLK_clks   <= 1'b0;
    end else begin
      state_r    <= state_s;
      ph_r       <= ph_s;
      pre_r      <= pre_s;
      halted     <= halted_s;
      cycle_done <= cycle_done_s;
      CLK_clk    <= pair_s[1];
      CLK_clkd   <= pair_s[0];
      CLK_clke   <= pair_s[1] | pair_s[0];
      CLK_clks   <= pair_s[1] & pair_s[0];
    end
  end

  jstepper u_stepper (
    .clk     (clk),
    .rst     (reset),
    .advance (advance_s),
    .stp_bus (STP_bus)
  );

endmodule

// File: tb/tb_jclock_stepper.sv
// Bench for jclock_stepper: DIV=1 and DIV=3 instances share stimulus and are
// compared every cycle against a tick-position reference model.
module tb_jclock_stepper;

  logic clk = 1'b0;
  logic reset, run, step, halt;

  logic       o_clk   [2];
  logic       o_clkd  [2];
  logic       o_clke  [2];
  logic       o_clks  [2];
  logic [0:5] o_stp   [2];
  logic       o_halted[2];
  logic       o_done  [2];

  int errors = 0;
  int checks = 0;

  int divs[2] = '{1, 3};
  int m_tpos[2];
  int m_step[2];
  bit m_halted[2];

  always #5 clk = ~clk;

  jclock_stepper #(.DIV(1)) dut_div1 (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt(halt),
    .CLK_clk(o_clk[0]), .CLK_clkd(o_clkd[0]), .CLK_clke(o_clke[0]), .CLK_clks(o_clks[0]),
    .STP_bus(o_stp[0]), .halted(o_halted[0]), .cycle_done(o_done[0])
  );

  jclock_stepper #(.DIV(3)) dut_div3 (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt(halt),
    .CLK_clk(o_clk[1]), .CLK_clkd(o_clkd[1]), .CLK_clke(o_clke[1]), .CLK_clks(o_clks[1]),
    .STP_bus(o_stp[1]), .halted(o_halted[1]), .cycle_done(o_done[1])
  );

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] observed(input int k);
    return {o_clk[k], o_clkd[k], o_clke[k], o_clks[k], o_stp[k], o_halted[k], o_done[k]};
  endfunction

  // Expected outputs from tick position: -1 is idle, else 0 .. 4*DIV-1.
  function automatic logic [11:0] expected(input int k);
    int ph;
    logic c, cd, done;
    logic [0:5] s;
    ph   = (m_tpos[k] < 0) ? 3 : m_tpos[k] / divs[k];
    c    = (ph == 0 || ph == 1);
    cd   = (ph == 1 || ph == 2);
    s    = 6'b000000;
    s[m_step[k]] = 1'b1;
    done = (m_tpos[k] == 4 * divs[k] - 1) && (m_step[k] == 5);
    return {c, cd, c | cd, c & cd, s, m_halted[k], done};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_tpos[k]   = -1;
      m_step[k]   = 5;
      m_halted[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_tpos[k]   = -1;
        m_step[k]   = 5;
        m_halted[k] = 1'b0;
      end else if (m_tpos[k] < 0) begin
        if (!m_halted[k] && (run || step)) begin
          m_tpos[k] = 0;
          m_step[k] = (m_step[k] + 1) % 6;
        end
      end else if (m_tpos[k] == 4 * divs[k] - 1) begin
        if (!m_halted[k] && run) begin
          m_tpos[k] = 0;
          m_step[k] = (m_step[k] + 1) % 6;
        end else begin
          m_tpos[k] = -1;
        end
      end else begin
        if (m_tpos[k] == 2 * divs[k] - 1 && m_step[k] == 5 && halt) m_halted[k] = 1'b1;
        m_tpos[k]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("%s[div%0d]", tag, divs[k]), observed(k), expected(k));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
    model_reset();
    repeat (3) cycle("reset");
    check_eq("reset_const", observed(0), 12'b0000_000001_00);

    // Free-running from reset release.
    run = 1'b1; reset = 1'b0;
    repeat (80) cycle("run_free");

    // Stop, then three single steps ten clocks apart.
    run = 1'b0;
    repeat (20) cycle("run_stop");
    repeat (3) begin
      step = 1'b1;
      cycle("step_pulse");
      step = 1'b0;
      repeat (9) cycle("step_gap");
    end

    // Drop run during phase 1 of the DIV=1 instance.
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle("run_to_ph1");
      seen = o_clks[0];
    end
    check_eq("ph1_reached", {11'b0, seen}, 12'd1);
    run = 1'b0;
    repeat (20) cycle("run_drop");

    // Asynchronous reset during phase 2 of step 3.
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cycle("run_to_s3p2");
      seen = o_clkd[0] && !o_clk[0] && o_stp[0][3];
    end
    check_eq("s3p2_reached", {11'b0, seen}, 12'd1);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    repeat (2) cycle("held_reset");
    reset = 1'b0;
    repeat (12) cycle("after_reset");

    // Halt held high: both instances stop after their step-5 tick.
    reset = 1'b1;
    model_reset();
    cycle("halt_reset");
    reset = 1'b0; halt = 1'b1;
    repeat (120) cycle("halt_run");
    halt = 1'b0;
    repeat (30) begin
      run  = ($urandom_range(0, 1) == 1);
      step = ($urandom_range(0, 2) == 0);
      cycle("halt_hold");
    end

    // Randomized run / step / halt / reset.
    reset = 1'b1; step = 1'b0;
    model_reset();
    cycle("rand_reset");
    reset = 1'b0;
    repeat (2500) begin
      run   = ($urandom_range(0, 3) != 0);
      step  = ($urandom_range(0, 7) == 0);
      halt  = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 149) == 0);
      if (reset) model_reset();
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jclock_stepper.md
# jclock_stepper

Clock-phase generator and 6-step stepper that drives the control unit's timing inputs. It produces CLK_clk, CLK_clkd, CLK_clke, CLK_clks and the one-hot STP_bus[0:5] from one system clock. It accepts the control unit's halt output and adds run and single-step control. It sits beside the control unit and feeds it every timing input it consumes.

## Interface
- DIV, default 1: system clocks per clock phase (≥1); one CPU tick = 4×DIV system clocks.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = free-running ticks, 0 = stop at the next tick boundary.
- step  in  1  single-clock pulse; requests exactly one tick while idle.
- halt  in  1  control unit halt request, combinational from the control unit.
- CLK_clk  out  1  CPU clock.
- CLK_clkd  out  1  CPU clock delayed by one phase.
- CLK_clke  out  1  enable window, CLK_clk | CLK_clkd.
- CLK_clks  out  1  set window, CLK_clk & CLK_clkd.
- STP_bus  out  [0:5]  one-hot current step.
- halted  out  1  sticky halt status.
- cycle_done  out  1  one-clock pulse when step 5's tick completes.

## Operation
- Phase counter ph ∈ {0,1,2,3}; prescaler counts DIV clocks per phase.
- Phase → (clk, clkd): 0 → (1,0); 1 → (1,1); 2 → (0,1); 3 → (0,0).
- clke is high in phases 0–2; clks is high in phase 1 only.
- All four clock outputs and STP_bus are registered and glitch-free.
- Idle state: ph = 3, all clock outputs 0.
- Tick: ph runs 0→1→2→3, DIV clocks each.
- Advancing from 3 to 0 also rotates STP_bus one position (bit 5 wraps to bit 0).
- At the end of phase 3:
  - If halted: stay idle.
  - Else if run=1: start the next tick immediately.
  - Else: go idle.
- While idle and not halted:
  - run=1 starts a tick on the next clock.
  - A step pulse starts exactly one tick.
  - step is ignored while a tick is in progress.
- Halt: halt is sampled on the last system clock of phase 1 while STP_bus[5]=1.
  - If it is 1, halted sets, the current tick finishes through phase 3, then the block goes idle.
  - halted is cleared only by reset; run and step have no effect while halted.
- cycle_done pulses on the last clock of phase 3 of any executed step-5 tick, including the halting tick. It never pulses in reset or idle.

## Timing
- Reset values: CLK_clk = CLK_clkd = CLK_clke = CLK_clks = 0; STP_bus = 000001 (pre-start); ph = 3; halted = 0; cycle_done = 0; prescaler = 0.
- First tick after reset runs in step 0 (STP_bus = 100000).
- Latency with DIV=1, run high at reset release:
  - CLK_clk rises 1 clock after the first edge with reset low.
  - CLK_clks is high for 1 clock, 1 clock after CLK_clk rises.
  - One instruction takes 24 clocks.
- STP_bus changes only on entry to phase 0, so it is stable across every clke/clks window.
- run falling mid-tick has no effect on the current tick.
- Reset asserted mid-tick forces all outputs to reset values asynchronously.
- step and run=1 together while idle start one tick, then continue free-running.
- DIV=1 prescaler is degenerate: phase advances every clock.

## Structure
- Shared package jtiming_pkg holds:
  - The phase constants PH_0..PH_3.
  - NSTEPS = 6.
  - The phase-to-(clk, clkd) decode function.
- Sub-module jstepper: a 6-bit one-hot ring with an advance input and asynchronous reset to 000001, instantiated once.
- The top level holds the prescaler, phase counter, run/step/halt control FSM (IDLE, TICK, HALTED) and output registers.

## Test plan
- DIV=1, run=1 from reset:
  - CLK_clk = 1100 and CLK_clks = 0100 repeating every 4 clocks.
  - STP_bus walks 100000→…→000001→100000.
  - cycle_done every 24 clocks.
- DIV=3, run=1: each phase lasts 3 clocks; CLK_clks high for 3 clocks per 12-clock tick; instruction takes 72 clocks.
- halt high during step 5, phase 1:
  - halted=1.
  - One cycle_done pulse.
  - Clocks stop at 0 with STP_bus=000001.
  - run and step then produce no change until reset.
- run=0, idle, three step pulses 10 clocks apart: exactly three ticks; STP_bus goes 100000, 010000, 001000; clocks 0 between ticks.
- run dropped during phase 1: that tick completes through phase 3, then idle; STP_bus holds.
- reset asserted during phase 2 of step 3: outputs immediately match the reset values; after release with run=1, the first tick is step 0.
